// File: rtl/sipo_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_frame_ctrl_if
//  Description : Bundle of the frame controller's serial-side and word-side
//                signals.
//                master : drives the strobes and consumer ready, observes status
//                slave  : the frame controller itself
//  Ports       : start, bit_valid, serial_in, par_ready, overrun_clr (to slave)
//                par_out[WIDTH], par_valid, busy, overrun, parity_err (from slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             bit_valid;
  logic             serial_in;
  logic             par_ready;
  logic             overrun_clr;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, bit_valid, serial_in, par_ready, overrun_clr,
    input  par_out, par_valid, busy, overrun, parity_err
  );

  modport slave (
    input  start, bit_valid, serial_in, par_ready, overrun_clr,
    output par_out, par_valid, busy, overrun, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_frame_ctrl
//  Description : Frame-level serial-to-parallel receive controller. Shifts
//                WIDTH bits (first bit ends up in the MSB) under a start /
//                bit strobe protocol, then hands the word to a one-entry
//                valid/ready output buffer. If the buffer is still occupied
//                the word is held in the shift stage and further bits are
//                dropped and flagged through the sticky overrun flag.
//  Option      : SIPO_FRAME_PARITY_EN - adds an even-parity bit after the data
//                bits; parity_err reports the check for the word in par_out.
//                When undefined, parity_err is tied low.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous, active-high reset
//                bus.slave  - start/bit_valid/serial_in/par_ready/overrun_clr in,
//                             par_out/par_valid/busy/overrun/parity_err out
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  sipo_frame_ctrl_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;
`ifdef SIPO_FRAME_PARITY_EN
  localparam logic [1:0] PARITY = 2'd3;
`endif

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_par_out;
  logic             r_par_valid;
  logic             r_overrun;

  logic             w_drain;
  logic             w_buf_free;
  logic [WIDTH-1:0] w_next_shreg;
  logic             w_last_data;
  logic             w_load_new;
  logic             w_load_held;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;

  // Buffer is free if empty or being drained on this very edge.
  assign w_drain      = r_par_valid && bus.par_ready;
  assign w_buf_free   = !r_par_valid || bus.par_ready;
  assign w_next_shreg = {r_shreg[WIDTH-2:0], bus.serial_in};
  // A start in SHIFT wins over a coincident bit strobe.
  assign w_last_data  = (r_state == SHIFT) && !bus.start && bus.bit_valid &&
                        (r_cnt == LAST_CNT);
  assign w_load_held  = (r_state == FULL) && w_drain;
  assign w_load       = w_load_new || w_load_held;

`ifdef SIPO_FRAME_PARITY_EN
  logic w_par_taken;
  logic w_parity_bit;
  logic r_pbit;
  logic r_parity_err;

  assign w_par_taken  = (r_state == PARITY) && !bus.start && bus.bit_valid;
  assign w_load_new   = w_par_taken && w_buf_free;
  // Data bits are already complete in the shift stage by the parity phase.
  assign w_load_val   = r_shreg;
  assign w_parity_bit = (r_state == FULL) ? r_pbit : bus.serial_in;

  // Parity bit is remembered so a stalled word keeps its check result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pbit       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_taken) begin
        r_pbit <= bus.serial_in;
      end
      if (w_load) begin
        r_parity_err <= (^r_shreg) ^ w_parity_bit;
      end
    end
  end

  assign bus.parity_err = r_parity_err;
`else
  assign w_load_new     = w_last_data && w_buf_free;
  assign w_load_val     = (r_state == FULL) ? r_shreg : w_next_shreg;
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_par_out   <= '0;
      r_par_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Output buffer: a load on the drain edge keeps valid high (back-to-back).
      if (w_load) begin
        r_par_out   <= w_load_val;
        r_par_valid <= 1'b1;
      end else if (w_drain) begin
        r_par_valid <= 1'b0;
      end

      // Set has priority over clear.
      if ((r_state == FULL) && bus.bit_valid) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= SHIFT;
            r_shreg <= '0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (bus.start) begin
            r_shreg <= '0;
            r_cnt   <= '0;
          end else if (bus.bit_valid) begin
            r_shreg <= w_next_shreg;
            r_cnt   <= r_cnt + CNT_ONE;
            if (w_last_data) begin
`ifdef SIPO_FRAME_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= w_buf_free ? IDLE : FULL;
`endif
            end
          end
        end
`ifdef SIPO_FRAME_PARITY_EN
        PARITY: begin
          if (bus.start) begin
            r_state <= SHIFT;
            r_shreg <= '0;
            r_cnt   <= '0;
          end else if (bus.bit_valid) begin
            r_state <= w_buf_free ? IDLE : FULL;
          end
        end
`endif
        FULL: begin
          if (w_drain) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.par_out   = r_par_out;
  assign bus.par_valid = r_par_valid;
  assign bus.busy      = (r_state != IDLE);
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
